dpram_wr_ctrl: RTL and testbench

- Write-side controller for the generic dual-port RAM.
- Accepts a valid/ready word stream with frame delimiters and drives the RAM write port (ce/we/addr/di) as a circular buffer.
- Publishes a committed write pointer, so the read-side consumer only sees whole frames.
- Rolls back partial frames on abort or oversize.

---
 rtl/dpram_wr_ctrl_if.sv | 26 ++
 rtl/dpram_wr_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_dpram_wr_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dpram_wr_ctrl_if.sv
// Stream-in and RAM write-port bundle for dpram_wr_ctrl.
// The producer drives the stream side; the controller drives s_ready and the RAM port.
interface dpram_wr_ctrl_if #(
  parameter int aw = 4,
  parameter int dw = 8
);
  logic          s_valid;
  logic          s_ready;
  logic [dw-1:0] s_data;
  logic          s_last;
  logic          s_abort;
  logic          ram_ce;
  logic          ram_we;
  logic [aw-1:0] ram_addr;
  logic [dw-1:0] ram_di;

  modport master (
    output s_valid, s_data, s_last, s_abort,
    input  s_ready, ram_ce, ram_we, ram_addr, ram_di
  );

  modport slave (
    input  s_valid, s_data, s_last, s_abort,
    output s_ready, ram_ce, ram_we, ram_addr, ram_di
  );
endinterface

// File: rtl/dpram_wr_ctrl.sv
// Circular-buffer write controller for a dual-port RAM; only whole frames become visible via wr_commit.
// Optional length-header slot per frame when DPRAM_WR_LEN_HDR_EN is defined.
module dpram_wr_ctrl #(
  parameter int aw      = 4,
  parameter int dw      = 8,
  parameter int max_len = 8
) (
  input  logic          clk,
  input  logic          rst,
  dpram_wr_ctrl_if.slave bus,
  input  logic [aw-1:0] rd_ptr,
  output logic [aw-1:0] wr_commit,
  output logic          frm_done,
  output logic [aw-1:0] frm_len,
  output logic          frm_drop
);
  localparam logic [aw-1:0] one     = aw'(1);
  localparam logic [aw-1:0] len_max = aw'(max_len);
`ifdef DPRAM_WR_LEN_HDR_EN
  // Header slot sits at the frame start, so data begins one slot later.
  localparam logic [aw-1:0] start_free = aw'(2);
  localparam logic [aw-1:0] first_off  = aw'(1);
`else
  localparam logic [aw-1:0] start_free = aw'(1);
  localparam logic [aw-1:0] first_off  = aw'(0);
`endif

  typedef enum logic [1:0] {
    IDLE,
    FILL,
`ifdef DPRAM_WR_LEN_HDR_EN
    HDR,
`endif
    DROP
  } state_t;

  state_t        state_reg, state_next;
  logic [aw-1:0] wr_ptr_reg, wr_ptr_next;
  logic [aw-1:0] len_reg, len_next;
  logic [aw-1:0] commit_reg, commit_next;
  logic          ce_reg, ce_next;
  logic [aw-1:0] addr_reg, addr_next;
  logic [dw-1:0] di_reg, di_next;
  logic          done_reg, done_next;
  logic [aw-1:0] flen_reg, flen_next;
  logic          drop_reg, drop_next;

  logic [aw-1:0] free;
  logic          ready;
  logic          abort_now;
  logic          accept;
  logic          rollback;

  always_comb begin
    state_next  = state_reg;
    wr_ptr_next = wr_ptr_reg;
    len_next    = len_reg;
    commit_next = commit_reg;
    ce_next     = 1'b0;
    addr_next   = addr_reg;
    di_next     = di_reg;
    done_next   = 1'b0;
    flen_next   = flen_reg;
    drop_next   = 1'b0;
    rollback    = 1'b0;

    free = rd_ptr - wr_ptr_reg - one;
    case (state_reg)
      IDLE:    ready = (free >= start_free);
      FILL:    ready = (free != '0);
      DROP:    ready = 1'b1;
      default: ready = 1'b0;
    endcase

    // Abort wins over a same-cycle beat, which is then not taken.
    abort_now = bus.s_abort && (state_reg == FILL || state_reg == DROP);
    accept    = bus.s_valid && ready && !abort_now;

    if (abort_now) begin
      rollback = 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            ce_next     = 1'b1;
            addr_next   = wr_ptr_reg + first_off;
            di_next     = bus.s_data;
            wr_ptr_next = wr_ptr_reg + first_off + one;
            len_next    = one;
            if (bus.s_last) begin
`ifdef DPRAM_WR_LEN_HDR_EN
              state_next  = HDR;
`else
              commit_next = wr_ptr_reg + one;
              done_next   = 1'b1;
              flen_next   = one;
`endif
            end else begin
              state_next = FILL;
            end
          end
        end
        FILL: begin
          if (accept) begin
            if (len_reg == len_max) begin
              if (bus.s_last) rollback = 1'b1;
              else            state_next = DROP;
            end else begin
              ce_next     = 1'b1;
              addr_next   = wr_ptr_reg;
              di_next     = bus.s_data;
              wr_ptr_next = wr_ptr_reg + one;
              len_next    = len_reg + one;
              if (bus.s_last) begin
`ifdef DPRAM_WR_LEN_HDR_EN
                state_next  = HDR;
`else
                commit_next = wr_ptr_reg + one;
                done_next   = 1'b1;
                flen_next   = len_reg + one;
                state_next  = IDLE;
`endif
              end
            end
          end
        end
        DROP: begin
          if (accept && bus.s_last) rollback = 1'b1;
        end
`ifdef DPRAM_WR_LEN_HDR_EN
        HDR: begin
          // Start address is still the committed pointer; wr_ptr is already past the data.
          ce_next             = 1'b1;
          addr_next           = commit_reg;
          di_next             = '0;
          di_next[aw-1:0]     = len_reg;
          commit_next         = wr_ptr_reg;
          done_next           = 1'b1;
          flen_next           = len_reg;
          state_next          = IDLE;
        end
`endif
        default: state_next = IDLE;
      endcase
    end

    if (rollback) begin
      wr_ptr_next = commit_reg;
      drop_next   = 1'b1;
      state_next  = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      wr_ptr_reg <= '0;
      len_reg    <= '0;
      commit_reg <= '0;
      ce_reg     <= 1'b0;
      addr_reg   <= '0;
      di_reg     <= '0;
      done_reg   <= 1'b0;
      flen_reg   <= '0;
      drop_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      wr_ptr_reg <= wr_ptr_next;
      len_reg    <= len_next;
      commit_reg <= commit_next;
      ce_reg     <= ce_next;
      addr_reg   <= addr_next;
      di_reg     <= di_next;
      done_reg   <= done_next;
      flen_reg   <= flen_next;
      drop_reg   <= drop_next;
    end
  end

  assign bus.s_ready  = ready;
  assign bus.ram_ce   = ce_reg;
  assign bus.ram_we   = ce_reg;
  assign bus.ram_addr = addr_reg;
  assign bus.ram_di   = di_reg;
  assign wr_commit    = commit_reg;
  assign frm_done     = done_reg;
  assign frm_len      = flen_reg;
  assign frm_drop     = drop_reg;
endmodule

// File: tb/tb_dpram_wr_ctrl.sv
// Bench for dpram_wr_ctrl: frame-level ring model checked every cycle, plus literal scenario checks.
module tb_dpram_wr_ctrl;
  localparam int AW   = 4;
  localparam int DW   = 8;
  localparam int MAXL = 10;
  localparam int M    = (1 << AW) - 1;
`ifdef DPRAM_WR_LEN_HDR_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] rd_ptr = '0;
  logic [AW-1:0] wr_commit;
  logic          frm_done;
  logic [AW-1:0] frm_len;
  logic          frm_drop;

  dpram_wr_ctrl_if #(.aw(AW), .dw(DW)) bus_if ();

  dpram_wr_ctrl #(.aw(AW), .dw(DW), .max_len(MAXL)) dut (
    .clk(clk), .rst(rst), .bus(bus_if), .rd_ptr(rd_ptr),
    .wr_commit(wr_commit), .frm_done(frm_done), .frm_len(frm_len), .frm_drop(frm_drop)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame-level ring model: write pointer, committed pointer, frame length and mode
  // (0 waiting for frame, 1 in frame, 2 discarding, 3 header slot pending).
  int m_wp, m_cm, m_len, m_mode;
  int e_ce, e_addr, e_di, e_done, e_flen, e_drop;
  int free_w;
  bit model_on = 1'b0;
  bit rdy, abt, acc, rb;
  int wr_addr_q[$];
  int wr_data_q[$];
  int done_len_q[$];
  int drop_cnt;

  always @(negedge clk) begin
    if (model_on) begin
      chk("ram_ce",    bus_if.ram_ce,   e_ce);
      chk("ram_we",    bus_if.ram_we,   e_ce);
      chk("ram_addr",  bus_if.ram_addr, e_addr);
      chk("ram_di",    bus_if.ram_di,   e_di);
      chk("wr_commit", wr_commit,       m_cm);
      chk("frm_done",  frm_done,        e_done);
      chk("frm_drop",  frm_drop,        e_drop);
      if (e_done != 0) chk("frm_len", frm_len, e_flen);
      if (bus_if.ram_ce) begin
        wr_addr_q.push_back(int'(bus_if.ram_addr));
        wr_data_q.push_back(int'(bus_if.ram_di));
      end
      if (frm_done) done_len_q.push_back(int'(frm_len));
      if (frm_drop) drop_cnt++;
    end
    if (rst) begin
      m_wp = 0; m_cm = 0; m_len = 0; m_mode = 0;
      e_ce = 0; e_addr = 0; e_di = 0; e_done = 0; e_flen = 0; e_drop = 0;
      model_on = 1'b1;
    end else if (model_on) begin
      free_w = (int'(rd_ptr) - m_wp - 1) & M;
      if (m_mode == 3)      rdy = 1'b0;
      else if (m_mode == 2) rdy = 1'b1;
      else if (m_mode == 0) rdy = (free_w >= (HDR ? 2 : 1));
      else                  rdy = (free_w != 0);
      chk("s_ready", bus_if.s_ready, rdy);
      abt = bus_if.s_abort && (m_mode == 1 || m_mode == 2);
      acc = bus_if.s_valid && rdy && !abt;
      e_ce = 0; e_done = 0; e_drop = 0; rb = 1'b0;
      if (m_mode == 3) begin
        e_ce = 1; e_addr = m_cm; e_di = m_len;
        m_cm = m_wp; e_done = 1; e_flen = m_len; m_mode = 0;
      end else if (abt) begin
        rb = 1'b1;
      end else if (acc) begin
        if (m_mode == 2) begin
          rb = bus_if.s_last;
        end else if (m_mode == 1 && m_len == MAXL) begin
          if (bus_if.s_last) rb = 1'b1;
          else               m_mode = 2;
        end else begin
          if (m_mode == 0) begin
            m_len = 0;
            if (HDR) m_wp = (m_wp + 1) & M;
          end
          e_ce = 1; e_addr = m_wp; e_di = int'(bus_if.s_data);
          m_wp = (m_wp + 1) & M;
          m_len++;
          if (!bus_if.s_last)  m_mode = 1;
          else if (HDR)        m_mode = 3;
          else begin
            m_cm = m_wp; e_done = 1; e_flen = m_len; m_mode = 0;
          end
        end
      end
      if (rb) begin
        m_wp = m_cm; e_drop = 1; m_mode = 0;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus_if.s_valid = 1'b0; bus_if.s_last = 1'b0; bus_if.s_abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rd_ptr = '0;
    wr_addr_q.delete(); wr_data_q.delete(); done_len_q.delete();
    drop_cnt = 0;
  endtask

  task automatic beat(input logic [7:0] d, input bit last);
    int n;
    n = 0;
    bus_if.s_valid = 1'b1; bus_if.s_data = d; bus_if.s_last = last;
    @(negedge clk);
    while (!bus_if.s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus_if.s_ready) chk("beat_ready", bus_if.s_ready, 1);
    @(posedge clk); #1;
    bus_if.s_valid = 1'b0; bus_if.s_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus_if.s_valid = 1'b0; bus_if.s_data = '0; bus_if.s_last = 1'b0; bus_if.s_abort = 1'b0;
    do_reset();
    chk("rst_commit", wr_commit, 0);
    chk("rst_ce", bus_if.ram_ce, 0);
    chk("rst_ready", bus_if.s_ready, 1);
`ifndef DPRAM_WR_LEN_HDR_EN
    // Three-word frame.
    beat(8'hA1, 0); beat(8'hA2, 0); beat(8'hA3, 1);
    idle(2);
    chk("t1_nwr", wr_addr_q.size(), 3);
    chk("t1_addr0", wr_addr_q[0], 0);
    chk("t1_addr2", wr_addr_q[2], 2);
    chk("t1_data2", wr_data_q[2], 8'hA3);
    chk("t1_commit", wr_commit, 3);
    chk("t1_len", done_len_q[0], 3);
    $display("t1 three-word frame: commit=%0d", wr_commit);

    // Single-word frame straight from idle.
    do_reset();
    beat(8'h5A, 1);
    idle(2);
    chk("t2_addr", wr_addr_q[0], 0);
    chk("t2_data", wr_data_q[0], 8'h5A);
    chk("t2_commit", wr_commit, 1);
    chk("t2_len", done_len_q[0], 1);
    chk("t2_ready", bus_if.s_ready, 1);
    $display("t2 single-word frame: commit=%0d", wr_commit);

    // Fill the ring, stall, then release by advancing rd_ptr.
    do_reset();
    for (int i = 0; i < 8; i++) beat(8'(8'h10 + i), i == 7);
    for (int i = 0; i < 7; i++) beat(8'(8'h20 + i), 0);
    chk("t3_full", bus_if.s_ready, 0);
    bus_if.s_valid = 1'b1; bus_if.s_data = 8'h30;
    idle(3);
    chk("t3_stall_nwr", wr_addr_q.size(), 15);
    rd_ptr = 4'd4;
    beat(8'h30, 0); beat(8'h31, 0); beat(8'h32, 1);
    idle(2);
    chk("t3_addr15", wr_addr_q[15], 15);
    chk("t3_addr16", wr_addr_q[16], 0);
    chk("t3_addr17", wr_addr_q[17], 1);
    chk("t3_commit", wr_commit, 2);
    chk("t3_len", done_len_q[1], 10);
    $display("t3 ring full and wrap: commit=%0d", wr_commit);

    // Abort mid-frame rolls back to the committed pointer.
    do_reset();
    beat(8'hC1, 0); beat(8'hC2, 0); beat(8'hC3, 1);
    beat(8'hD1, 0); beat(8'hD2, 0);
    bus_if.s_abort = 1'b1; bus_if.s_valid = 1'b1; bus_if.s_data = 8'hEE;
    idle(1);
    bus_if.s_abort = 1'b0; bus_if.s_valid = 1'b0;
    idle(1);
    chk("t4_drop", drop_cnt, 1);
    chk("t4_commit_hold", wr_commit, 3);
    beat(8'h77, 1);
    idle(2);
    chk("t4_addr", wr_addr_q[wr_addr_q.size() - 1], 3);
    chk("t4_commit", wr_commit, 4);
    $display("t4 abort and restart: commit=%0d", wr_commit);

    // Oversize frame is discarded.
    do_reset();
    for (int i = 0; i < 12; i++) beat(8'(8'h40 + i), i == 11);
    idle(2);
    chk("t5_nwr", wr_addr_q.size(), MAXL);
    chk("t5_drop", drop_cnt, 1);
    chk("t5_ndone", done_len_q.size(), 0);
    chk("t5_commit", wr_commit, 0);
    $display("t5 oversize frame: drops=%0d", drop_cnt);

    // Reset mid-frame discards silently.
    do_reset();
    beat(8'h91, 0); beat(8'h92, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
    chk("t6_drop", drop_cnt, 0);
    beat(8'h42, 1);
    idle(2);
    chk("t6_addr", wr_addr_q[wr_addr_q.size() - 1], 0);
    chk("t6_commit", wr_commit, 1);
    $display("t6 reset mid-frame: commit=%0d", wr_commit);
`else
    // Two-word frame with a length header at the start slot.
    beat(8'hB1, 0); beat(8'hB2, 1);
    chk("h_ready", bus_if.s_ready, 0);
    idle(2);
    chk("h_nwr", wr_addr_q.size(), 3);
    chk("h_addr0", wr_addr_q[0], 1);
    chk("h_addr1", wr_addr_q[1], 2);
    chk("h_addr2", wr_addr_q[2], 0);
    chk("h_hdr", wr_data_q[2], 2);
    chk("h_commit", wr_commit, 3);
    chk("h_len", done_len_q[0], 2);
    $display("th header frame: commit=%0d", wr_commit);
    for (int i = 0; i < 12; i++) beat(8'(8'h40 + i), i == 11);
    idle(2);
    chk("h_oversize_drop", drop_cnt, 1);
    chk("h_oversize_commit", wr_commit, 3);
    $display("th oversize frame: drops=%0d", drop_cnt);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end
endmodule
